// File: rtl/mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter
//
// Purpose:
//   Shares one Avalon-style memory slave between two masters.
//   Master 0 is the mips_cpu_bus port, master 1 a secondary requester
//   (program loader / debug DMA). Grants are round-robin and are held for
//   one complete transfer. Slave waitrequest and readdata are forwarded.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   m0_* / m1_*   : master request ports (address, read, write, writedata,
//                   byteenable in; waitrequest out)
//   m_readdata    : slave readdata broadcast to both masters
//   s_*           : muxed slave request (address, read, write, writedata,
//                   byteenable out; waitrequest, readdata in)
//   m0_grant_count, m1_grant_count : completion counters, only when
//                   ARB_STATS_EN is defined
//
// Configuration macro:
//   ARB_STATS_EN - adds 16-bit saturating per-master completion counters.
// ---------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,

`ifdef ARB_STATS_EN
    output logic [15:0]           m0_grant_count,
    output logic [15:0]           m1_grant_count,
`endif

    output logic [DATA_W-1:0]     m_readdata,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    // Master served most recently; the other one wins a tie in IDLE.
    logic   last, last_nxt;
    logic   req0, req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Readdata is broadcast unconditionally; masters only look at it in
    // the completion cycle of their own read.
    assign m_readdata = s_readdata;

    // The state register resets asynchronously, so the slave strobes and
    // waitrequests (decoded from state) fall back to their IDLE values the
    // moment reset is asserted, even mid-transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? GRANT0 : GRANT1;
                else if (req0)
                    state_nxt = GRANT0;
                else if (req1)
                    state_nxt = GRANT1;
            end

            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                // A request withdrawn before completion is abandoned
                // without updating the round-robin pointer.
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    last_nxt  = 1'b0;
                    state_nxt = req1 ? GRANT1 : IDLE;
                end
            end

            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (!s_waitrequest) begin
                    last_nxt  = 1'b1;
                    state_nxt = req0 ? GRANT0 : IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    logic done0, done1;

    assign done0 = (state == GRANT0) && req0 && !s_waitrequest;
    assign done1 = (state == GRANT1) && req1 && !s_waitrequest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_grant_count <= 16'h0000;
            m1_grant_count <= 16'h0000;
        end else begin
            if (done0 && (m0_grant_count != 16'hFFFF))
                m0_grant_count <= m0_grant_count + 16'd1;
            if (done1 && (m1_grant_count != 16'hFFFF))
                m1_grant_count <= m1_grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_bus_arbiter
//
// Purpose:
//   Self-checking bench for mips_bus_arbiter. Two queue-driven masters and a
//   slave with a configurable stall count. Every completed transfer seen on
//   the slave side is recorded and compared against an expected-order
//   scoreboard; scenario tasks also check per-cycle grant/stall behaviour.
//
// Ports: none (top-level bench). Honours ARB_STATS_EN like the design.
// ---------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    localparam logic [31:0] RD_KEY = 32'h5A5A_5A5A;

    typedef struct packed {
        logic        mst;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    logic        clk;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m_readdata;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
`ifdef ARB_STATS_EN
    logic [15:0] m0_grant_count, m1_grant_count;
`endif

    int   checks;
    int   errors;
    int   cnt;        // remaining stall cycles of the current slave access
    int   stall_cfg;  // stall cycles applied to each new slave access
    txn_t q0[$];
    txn_t q1[$];
    txn_t expq[$];
    txn_t obsq[$];

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
`ifdef ARB_STATS_EN
        .m0_grant_count (m0_grant_count),
        .m1_grant_count (m1_grant_count),
`endif
        .m_readdata     (m_readdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: readdata is a fixed function of the address.
    assign s_readdata    = s_address ^ RD_KEY;
    assign s_waitrequest = (cnt != 0);

    function automatic txn_t mk(input logic mst, input logic [31:0] addr,
                                input logic wr, input logic [31:0] data,
                                input logic [3:0] be);
        txn_t t;
        t.mst = mst; t.addr = addr; t.wr = wr; t.data = data; t.be = be;
        t.rdata = 32'h0;
        return t;
    endfunction

    function automatic txn_t expect_of(input txn_t t);
        txn_t x;
        x = t;
        x.rdata = t.wr ? 32'h0 : (t.addr ^ RD_KEY);
        return x;
    endfunction

    function automatic txn_t snap(input logic mst);
        txn_t t;
        t.mst = mst; t.addr = s_address; t.wr = s_write;
        t.data = s_writedata; t.be = s_byteenable;
        t.rdata = s_read ? m_readdata : 32'h0;
        return t;
    endfunction

    task automatic drive();
        if (q0.size() > 0) begin
            m0_address = q0[0].addr; m0_read = !q0[0].wr; m0_write = q0[0].wr;
            m0_writedata = q0[0].data; m0_byteenable = q0[0].be;
        end else begin
            m0_read = 1'b0; m0_write = 1'b0;
        end
        if (q1.size() > 0) begin
            m1_address = q1[0].addr; m1_read = !q1[0].wr; m1_write = q1[0].wr;
            m1_writedata = q1[0].data; m1_byteenable = q1[0].be;
        end else begin
            m1_read = 1'b0; m1_write = 1'b0;
        end
    endtask

    // One clock: record completions at the falling edge, then after the
    // rising edge advance the slave stall counter and the master queues.
    task automatic tick();
        logic act;
        @(negedge clk);
        act = s_read | s_write;
        if ((m0_read | m0_write) && !m0_waitrequest) begin
            obsq.push_back(snap(1'b0));
            if (q0.size() > 0) q0.delete(0);
        end
        if ((m1_read | m1_write) && !m1_waitrequest) begin
            obsq.push_back(snap(1'b1));
            if (q1.size() > 0) q1.delete(0);
        end
        @(posedge clk);
        #1;
        if (act) begin
            if (cnt == 0) cnt = stall_cfg;
            else          cnt = cnt - 1;
        end
        drive();
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && (q0.size() + q1.size()) > 0; i++) tick();
        checks++;
        if ((q0.size() + q1.size()) != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, q0.size() + q1.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q0.delete(); q1.delete();
        cnt = 0; stall_cfg = 0;
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m0_read = 1'b1; m1_write = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=0011",
                     {s_read, s_write, m0_waitrequest, m1_waitrequest});
        end
`ifdef ARB_STATS_EN
        checks++;
        if ({m0_grant_count, m1_grant_count} !== 32'h0) begin
            errors++;
            $display("FAIL reset_counts got=%h required=0", {m0_grant_count, m1_grant_count});
        end
`endif
        m0_read = 1'b0; m1_write = 1'b0;
        reset = 1'b1;
        #1;
        tick();
        checks++;
        if ({s_read, s_write, m0_waitrequest} !== 3'b001) begin
            errors++;
            $display("FAIL reset_idle got=%b required=001", {s_read, s_write, m0_waitrequest});
        end
    endtask

    task automatic test_single_read();
        txn_t t, e, o;
        stall_cfg = 0; cnt = 0;
        t = mk(1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 4'hF);
        q0.push_back(t); expq.push_back(expect_of(t));
        drive(); #1;
        checks++;
        if ({s_read, m0_waitrequest} !== 2'b01) begin
            errors++;
            $display("FAIL single_arb_cycle got=%b required=01", {s_read, m0_waitrequest});
        end
        tick();
        checks++;
        if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b101 || s_address !== 32'hBFC0_0000
            || m_readdata !== (32'hBFC0_0000 ^ RD_KEY)) begin
            errors++;
            $display("FAIL single_grant got=%b/%h/%h required=101/bfc00000/%h",
                     {s_read, m0_waitrequest, m1_waitrequest}, s_address, m_readdata,
                     32'hBFC0_0000 ^ RD_KEY);
        end
        tick();
        checks++;
        if ({s_read, m0_waitrequest} !== 2'b01) begin
            errors++;
            $display("FAIL single_release got=%b required=01", {s_read, m0_waitrequest});
        end
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL single_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL single_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL single_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_tie();
        txn_t a, b, e, o;
        do_reset();
        a = mk(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
        b = mk(1'b1, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 4'hF);
        q0.push_back(a); q1.push_back(b);
        expq.push_back(expect_of(a)); expq.push_back(expect_of(b));
        drive(); #1;
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b01 || s_address !== 32'h100) begin
            errors++;
            $display("FAIL tie_first got=%b/%h required=01/00000100", {m0_waitrequest, m1_waitrequest}, s_address);
        end
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest, s_write} !== 3'b101 || s_address !== 32'h200) begin
            errors++;
            $display("FAIL tie_second got=%b/%h required=101/00000200",
                     {m0_waitrequest, m1_waitrequest, s_write}, s_address);
        end
        drain("tie");
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL tie_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL tie_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL tie_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_stall_write();
        txn_t w, r, e, o;
        stall_cfg = 3; cnt = 3;
        w = mk(1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        r = mk(1'b0, 32'h0000_0020, 1'b0, 32'h0, 4'hF);
        q1.push_back(w);
        expq.push_back(expect_of(w)); expq.push_back(expect_of(r));
        drive(); #1;
        tick();
        q0.push_back(r);
        drive(); #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_write, s_read} !== 2'b10 || s_address !== 32'h10 || s_writedata !== 32'hDEAD_BEEF
                || s_byteenable !== 4'b0011 || m0_waitrequest !== 1'b1
                || m1_waitrequest !== (i < 3)) begin
                errors++;
                $display("FAIL stall_cycle%0d got=%b/%h/%h/%b/%b%b required=10/00000010/deadbeef/0011/1%0d",
                         i, {s_write, s_read}, s_address, s_writedata, s_byteenable,
                         m0_waitrequest, m1_waitrequest, (i < 3));
            end
            tick();
        end
        drain("stall");
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL stall_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL stall_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL stall_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_back_to_back();
        txn_t t0, t1, e, o;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            t0 = mk(1'b0, 32'h0000_1000 + 32'(i * 4), 1'b0, 32'h0, 4'hF);
            t1 = mk(1'b1, 32'h0000_2000 + 32'(i * 4), 1'b1, 32'hC0DE_0000 + 32'(i), 4'(i + 1));
            q0.push_back(t0); q1.push_back(t1);
            expq.push_back(expect_of(t0)); expq.push_back(expect_of(t1));
        end
        drive(); #1;
        drain("b2b");
`ifdef ARB_STATS_EN
        checks++;
        if (m0_grant_count !== 16'd4 || m1_grant_count !== 16'd4) begin
            errors++;
            $display("FAIL b2b_counts got=%0d/%0d required=4/4", m0_grant_count, m1_grant_count);
        end
`endif
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL b2b_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL b2b_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_reset_mid();
        txn_t a, b, e, o;
        stall_cfg = 5; cnt = 5;
        q1.push_back(mk(1'b1, 32'h0000_0300, 1'b0, 32'h0, 4'hF));
        drive(); #1;
        tick();
        checks++;
        if ({s_read, m1_waitrequest} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre got=%b required=11", {s_read, m1_waitrequest});
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
            errors++;
            $display("FAIL rstmid_abort got=%b required=0011",
                     {s_read, s_write, m0_waitrequest, m1_waitrequest});
        end
        q1.delete(); drive();
        @(posedge clk); #1;
        reset = 1'b1; stall_cfg = 0; cnt = 0;
        a = mk(1'b0, 32'h0000_0400, 1'b0, 32'h0, 4'hF);
        b = mk(1'b1, 32'h0000_0500, 1'b0, 32'h0, 4'hF);
        q0.push_back(a); q1.push_back(b);
        expq.push_back(expect_of(a)); expq.push_back(expect_of(b));
        drive(); #1;
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_tie got=%b required=01", {m0_waitrequest, m1_waitrequest});
        end
        drain("rstmid");
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL rstmid_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL rstmid_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL rstmid_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_drop();
        txn_t w, e, o;
        stall_cfg = 4; cnt = 4;
        q0.push_back(mk(1'b0, 32'h0000_0600, 1'b0, 32'h0, 4'hF));
        drive(); #1;
        tick();
        w = mk(1'b1, 32'h0000_0700, 1'b1, 32'h1234_5678, 4'b1100);
        q1.push_back(w); expq.push_back(expect_of(w));
        drive(); #1;
        checks++;
        if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b111) begin
            errors++;
            $display("FAIL drop_stalled got=%b required=111", {s_read, m0_waitrequest, m1_waitrequest});
        end
        q0.delete(0); drive(); #1;
        tick();
        cnt = 0; stall_cfg = 0;
        checks++;
        if ({s_read, s_write, m1_waitrequest} !== 3'b001) begin
            errors++;
            $display("FAIL drop_idle got=%b required=001", {s_read, s_write, m1_waitrequest});
        end
        tick();
        checks++;
        if ({s_write, m1_waitrequest} !== 2'b10 || s_address !== 32'h700) begin
            errors++;
            $display("FAIL drop_regrant got=%b/%h required=10/00000700", {s_write, m1_waitrequest}, s_address);
        end
        drain("drop");
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL drop_sb got=none required=%h", e); end
            else begin o = obsq.pop_front();
                if (o !== e) begin errors++; $display("FAIL drop_sb got=%h required=%h", o, e); end end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL drop_sb_extra got=%0d required=0", obsq.size()); obsq.delete(); end
    endtask

    initial begin
        checks = 0; errors = 0; cnt = 0; stall_cfg = 0;
        reset = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        test_reset();
        test_single_read();
        test_tie();
        test_stall_write();
        test_back_to_back();
        test_reset_mid();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
